// File: rtl/reduce_acc_i8v4_if.sv
// Stream bundle for reduce_acc_i8v4: i8v4 vector input stream and packet-sum output stream.
interface reduce_acc_i8v4_if #(
   parameter int ACC_W = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [7:0]       y_0;
   logic [7:0]       y_1;
   logic [7:0]       y_2;
   logic [7:0]       y_3;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] out_sum;
   logic             out_ovf;

   modport master (
      output in_valid, y_0, y_1, y_2, y_3, out_ready,
      input  in_ready, out_valid, out_sum, out_ovf
   );

   modport slave (
      input  in_valid, y_0, y_1, y_2, y_3, out_ready,
      output in_ready, out_valid, out_sum, out_ovf
   );
endinterface

// File: rtl/reduce_acc_i8v4.sv
// Reduces BEATS signed i8v4 vectors to one signed ACC_W sum with sticky overflow.
// Define ACC_SAT_EN for saturating accumulation; default build wraps modulo 2^ACC_W.
module reduce_acc_i8v4 #(
   parameter int BEATS = 4,
   parameter int ACC_W = 16
) (
   input  logic               clock,
   input  logic               reset,
   reduce_acc_i8v4_if.slave   bus
);

   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);
   localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   typedef enum logic {
      ACC,
      OUT
   } state_t;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic                    ovf_q, ovf_d;
   logic signed [ACC_W-1:0] out_sum_q, out_sum_d;
   logic                    out_ovf_q, out_ovf_d;
   logic                    out_valid_q, out_valid_d;

   logic signed [9:0]       lane_sum;
   logic signed [ACC_W-1:0] lane_ext;
   logic signed [ACC_W-1:0] add_res;
   logic                    add_ovf;
   logic                    in_ready;
   logic                    accept;

   // Four 8-bit lanes fit in 10 bits (-512..508), so this add cannot overflow.
   always_comb begin
      lane_sum = {{2{bus.y_0[7]}}, bus.y_0} + {{2{bus.y_1[7]}}, bus.y_1}
               + {{2{bus.y_2[7]}}, bus.y_2} + {{2{bus.y_3[7]}}, bus.y_3};
      lane_ext = ACC_W'(lane_sum);
   end

`ifdef ACC_SAT_EN
   logic signed [ACC_W:0] wide_sum;

   always_comb begin
      wide_sum = {acc_q[ACC_W-1], acc_q} + {lane_ext[ACC_W-1], lane_ext};
      add_ovf  = wide_sum[ACC_W] != wide_sum[ACC_W-1];
      if (add_ovf) begin
         add_res = wide_sum[ACC_W] ? ACC_MIN : ACC_MAX;
      end else begin
         add_res = wide_sum[ACC_W-1:0];
      end
   end
`else
   // Overflow when both operands share a sign that the result does not.
   always_comb begin
      add_res = acc_q + lane_ext;
      add_ovf = (acc_q[ACC_W-1] == lane_ext[ACC_W-1]) &&
                (add_res[ACC_W-1] != acc_q[ACC_W-1]);
   end
`endif

   assign in_ready = (state_q == ACC) && reset;
   assign accept   = bus.in_valid && in_ready;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      ovf_d       = ovf_q;
      out_sum_d   = out_sum_q;
      out_ovf_d   = out_ovf_q;
      out_valid_d = out_valid_q;
      case (state_q)
         ACC: begin
            if (accept) begin
               acc_d = add_res;
               ovf_d = ovf_q | add_ovf;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LAST) begin
                  out_sum_d   = add_res;
                  out_ovf_d   = ovf_q | add_ovf;
                  out_valid_d = 1'b1;
                  state_d     = OUT;
               end
            end
         end
         OUT: begin
            if (out_valid_q && bus.out_ready) begin
               out_valid_d = 1'b0;
               acc_d       = '0;
               ovf_d       = 1'b0;
               cnt_d       = '0;
               state_d     = ACC;
            end
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= ACC;
         cnt_q       <= '0;
         acc_q       <= '0;
         ovf_q       <= 1'b0;
         out_sum_q   <= '0;
         out_ovf_q   <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         ovf_q       <= ovf_d;
         out_sum_q   <= out_sum_d;
         out_ovf_q   <= out_ovf_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_sum   = out_sum_q;
   assign bus.out_ovf   = out_ovf_q;

endmodule
